// File: rtl/apb_pkg.sv
// apb_pkg: APB bridge state encoding and default timeout shared with the APB RAM bench.
package apb_pkg;
  typedef logic [1:0] apb_state_t;
  localparam apb_state_t IDLE = 2'd0;
  localparam apb_state_t SETUP = 2'd1;
  localparam apb_state_t ACCESS = 2'd2;
  localparam apb_state_t RESP = 2'd3;
  localparam int APB_TIMEOUT = 16;
endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command/response to APB master with access timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  apb_state_t state;
  logic [7:0] cnt;
  assign cmd_ready = state == IDLE;
  assign psel = state == SETUP || state == ACCESS;
  assign penable = state == ACCESS;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state <= SETUP;
          pwrite <= cmd_write;
          paddr <= cmd_addr;
          pwdata <= cmd_wdata;
          cnt <= '0;
        end
        SETUP: state <= ACCESS;
        ACCESS: if (pready) begin
          state <= RESP;
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_err <= pslverr;
          rsp_timeout <= 1'b0;
        end else begin
          // cnt+1 is the number of ACCESS cycles spent waiting so far
          cnt <= cnt + 8'd1;
          if (cnt == 8'(TIMEOUT - 1)) begin
            state <= RESP;
            rsp_rdata <= '0;
            rsp_err <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        default: if (rsp_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB bridge against a 16-entry APB RAM model.
module tb_apb_master_bridge;
  logic clk, presetn, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
  logic rsp_err, rsp_timeout, psel, penable, pwrite, pready, pslverr, ready_en;
  logic [31:0] cmd_addr, paddr;
  logic [7:0] cmd_wdata, rsp_rdata, pwdata, prdata;
  logic [7:0] mem [16];
  int vectors = 0, errs = 0;
  int ps_n, pe_n, lat;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pready = ready_en;
  assign pslverr = paddr >= 32'd16;
  assign prdata = mem[paddr[3:0]];
  always @(posedge clk)
    if (psel && penable && pready && pwrite && paddr < 32'd16) mem[paddr[3:0]] <= pwdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; ps_n = 0; pe_n = 0;
    while (!rsp_valid && lat < 40) begin
      ps_n += int'(psel); pe_n += int'(penable);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    presetn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; ready_en = 1'b1;
    #3 presetn = 1'b0;
    #4;
    chk("rst_psel", psel, 0); chk("rst_penable", penable, 0); chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0); chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0); chk("rst_err", rsp_err, 0); chk("rst_timeout", rsp_timeout, 0);
    @(negedge clk);
    presetn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    // write 0xA5 to addr 3, immediate pready
    issue(1'b1, 32'd3, 8'hA5);
    chk("wr_lat", lat, 3); chk("wr_psel_cycles", ps_n, 2); chk("wr_pen_cycles", pe_n, 1);
    chk("wr_err", rsp_err, 0); chk("wr_rdata", rsp_rdata, 0); chk("wr_to", rsp_timeout, 0);
    chk("wr_psel_off", psel, 0); chk("wr_cmd_ready", cmd_ready, 0);
    take();
    chk("wr_idle", cmd_ready, 1);
    issue(1'b0, 32'd3, 8'h00);
    chk("rd_lat", lat, 3); chk("rd_rdata", rsp_rdata, 8'hA5); chk("rd_err", rsp_err, 0);
    take();
    issue(1'b1, 32'd20, 8'h11);
    chk("slverr_err", rsp_err, 1); chk("slverr_to", rsp_timeout, 0); chk("slverr_rdata", rsp_rdata, 0);
    take();
    ready_en = 1'b0;
    issue(1'b0, 32'd3, 8'h00);
    chk("to_lat", lat, 6); chk("to_psel_cycles", ps_n, 5); chk("to_pen_cycles", pe_n, 4);
    chk("to_psel_off", psel, 0); chk("to_err", rsp_err, 1); chk("to_to", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 0);
    take();
    // pready arriving on the last allowed ACCESS cycle beats the timeout
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("edge_penable", penable, 1);
    ready_en = 1'b1;
    @(negedge clk);
    chk("edge_valid", rsp_valid, 1); chk("edge_to", rsp_timeout, 0);
    chk("edge_err", rsp_err, 0); chk("edge_rdata", rsp_rdata, 8'hA5);
    take();
    // backpressured response with a pending command
    issue(1'b0, 32'd3, 8'h00);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd7; cmd_wdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", cmd_ready, 0); chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 8'hA5); chk("bp_err", rsp_err, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release_ready", cmd_ready, 1); chk("bp_release_valid", rsp_valid, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_accept_psel", psel, 1); chk("bp_accept_paddr", paddr, 7); chk("bp_accept_pwdata", pwdata, 8'h5A);
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("bp_second_lat", lat, 2);
    take();
    // reset mid-ACCESS
    ready_en = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd9; cmd_wdata = 8'h77;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_penable", penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("mid_psel", psel, 0); chk("mid_pen", penable, 0); chk("mid_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 1); chk("mid_paddr", paddr, 0);
    @(negedge clk);
    presetn = 1'b1; ready_en = 1'b1;
    issue(1'b1, 32'd5, 8'h3C);
    chk("post_wr_lat", lat, 3); chk("post_wr_err", rsp_err, 0);
    take();
    issue(1'b0, 32'd5, 8'h00);
    chk("post_rd_rdata", rsp_rdata, 8'h3C);
    take();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
